rnb_updnld: RTL and testbench

- Parametrised successor to the fixed 16-bit up/down loadable register.
- Generalised in width and step size; wrap or saturate mode selected by parameter.
- Adds carry/borrow and zero status, and a registered bus-drive output for the transfer bus.
- Used for PC/SP/address-pointer style registers in the pipelined CPU datapath.

---
 rtl/rnb_pkg.sv | 19 +
 rtl/rnb_addsub.sv | 32 +++
 rtl/rnb_updnld.sv | 64 ++++++
 tb/tb_rnb_updnld.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rnb_pkg.sv
// Shared constants, flag struct and step zero-extension helper for rnb_updnld.
package rnb_pkg;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;
  localparam int MAX_W     = 32;

  typedef struct packed {
    logic carry;
    logic borrow;
  } rnb_flags_t;

  // Keep only the low min(step_w, width) bits so a wide step cannot alias high bits.
  function automatic logic [MAX_W-1:0] step_zext(input logic [MAX_W-1:0] s,
                                                 input int step_w, input int width);
    int w;
    w = (step_w < width) ? step_w : width;
    return (w >= MAX_W) ? s : (s & ((MAX_W'(1) << w) - MAX_W'(1)));
  endfunction
endpackage

// File: rtl/rnb_addsub.sv
// Combinational WIDTH+1-bit add/subtract with optional clamp on overflow/underflow.
module rnb_addsub
  import rnb_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] stp,
  input  logic             up,
  input  logic             dn,
  output logic [WIDTH-1:0] nxt,
  output logic             cy,
  output logic             bw
);
  logic [WIDTH:0] sum, diff;

  always_comb begin
    sum  = {1'b0, cur} + {1'b0, stp};
    diff = {1'b0, cur} - {1'b0, stp};
    nxt  = cur;
    cy   = 1'b0;
    bw   = 1'b0;
    if (up) begin
      cy  = sum[WIDTH];
      nxt = (cy && SATURATE == MODE_SAT) ? '1 : sum[WIDTH-1:0];
    end else if (dn) begin
      bw  = diff[WIDTH];
      nxt = (bw && SATURATE == MODE_SAT) ? '0 : diff[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/rnb_updnld.sv
// Parametrised up/down loadable register with carry/borrow pulses and registered bus drive.
module rnb_updnld
  import rnb_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               STEP_W    = 4,
  parameter int               SATURATE  = MODE_WRAP,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_load,
  input  logic              reg_write,
  input  logic              inc,
  input  logic              dec,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  XferBusIn,
  output logic [WIDTH-1:0]  Out,
  output logic [WIDTH-1:0]  XferBusOut,
  output logic              bus_valid,
  output logic              zero,
  output logic              carry,
  output logic              borrow
);
  logic [WIDTH-1:0] reg_q, stp, nxt;
  logic             do_inc, do_dec, cy, bw;
  rnb_flags_t       flags_q;

  assign stp    = WIDTH'(step_zext(MAX_W'(step), STEP_W, WIDTH));
  // Load wins; inc and dec together cancel to a hold.
  assign do_inc = ~reg_load & inc & ~dec;
  assign do_dec = ~reg_load & dec & ~inc;

  rnb_addsub #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_addsub (
    .cur (reg_q),
    .stp (stp),
    .up  (do_inc),
    .dn  (do_dec),
    .nxt (nxt),
    .cy  (cy),
    .bw  (bw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q      <= RESET_VAL;
      XferBusOut <= '0;
      bus_valid  <= 1'b0;
      flags_q    <= '0;
    end else begin
      reg_q          <= reg_load ? XferBusIn : nxt;
      // Bus carries the value at the sampling edge, enabling read-then-post-increment.
      XferBusOut     <= reg_write ? reg_q : '0;
      bus_valid      <= reg_write;
      flags_q.carry  <= cy;
      flags_q.borrow <= bw;
    end
  end

  assign Out    = reg_q;
  assign zero   = (reg_q == '0);
  assign carry  = flags_q.carry;
  assign borrow = flags_q.borrow;
endmodule

// File: tb/tb_rnb_updnld.sv
// Bench for rnb_updnld: 16-bit wrap instance and 8-bit saturating instance against an integer model.
module tb_rnb_updnld;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        ld16 = 0, wr16 = 0, inc16 = 0, dec16 = 0;
  logic [3:0]  st16 = 0;
  logic [15:0] din16 = 0;
  logic [15:0] out16, bus16;
  logic        vld16, z16, cy16, bw16;

  logic        ld8 = 0, wr8 = 0, inc8 = 0, dec8 = 0;
  logic [3:0]  st8 = 0;
  logic [7:0]  din8 = 0;
  logic [7:0]  out8, bus8;
  logic        vld8, z8, cy8, bw8;

  rnb_updnld #(.WIDTH(16), .STEP_W(4), .SATURATE(0), .RESET_VAL(16'h0100)) u16 (
    .clk(clk), .rst_n(rst_n), .reg_load(ld16), .reg_write(wr16), .inc(inc16), .dec(dec16),
    .step(st16), .XferBusIn(din16), .Out(out16), .XferBusOut(bus16), .bus_valid(vld16),
    .zero(z16), .carry(cy16), .borrow(bw16));

  rnb_updnld #(.WIDTH(8), .STEP_W(4), .SATURATE(1), .RESET_VAL(8'h00)) u8 (
    .clk(clk), .rst_n(rst_n), .reg_load(ld8), .reg_write(wr8), .inc(inc8), .dec(dec8),
    .step(st8), .XferBusIn(din8), .Out(out8), .XferBusOut(bus8), .bus_valid(vld8),
    .zero(z8), .carry(cy8), .borrow(bw8));

  int tests = 0, fails = 0;
  bit armed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: integer arithmetic against the range [0, maxv].
  int m16, mb16, mv16, mc16, mw16;
  int m8, mb8, mv8, mc8, mw8;

  function automatic int mstep(input int cur, input int s, input bit up, input int maxv,
                               input bit sat, output bit fl);
    int r;
    r = up ? cur + s : cur - s;
    fl = 0;
    if (r > maxv) begin fl = 1; r = sat ? maxv : r - (maxv + 1); end
    else if (r < 0) begin fl = 1; r = sat ? 0 : r + (maxv + 1); end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit fl;
    if (!rst_n) begin
      m16 = 'h0100; mb16 = 0; mv16 = 0; mc16 = 0; mw16 = 0;
      m8  = 0;      mb8  = 0; mv8  = 0; mc8  = 0; mw8  = 0;
    end else begin
      mb16 = wr16 ? m16 : 0; mv16 = int'(wr16); mc16 = 0; mw16 = 0;
      if (ld16) m16 = int'(din16);
      else if (inc16 != dec16) begin
        m16 = mstep(m16, int'(st16), inc16, 65535, 0, fl);
        if (inc16) mc16 = int'(fl); else mw16 = int'(fl);
      end
      mb8 = wr8 ? m8 : 0; mv8 = int'(wr8); mc8 = 0; mw8 = 0;
      if (ld8) m8 = int'(din8);
      else if (inc8 != dec8) begin
        m8 = mstep(m8, int'(st8), inc8, 255, 1, fl);
        if (inc8) mc8 = int'(fl); else mw8 = int'(fl);
      end
    end
  end

  always @(negedge clk) if (armed) begin
    chk("m_out16", 32'(out16), m16);   chk("m_bus16", 32'(bus16), mb16);
    chk("m_vld16", 32'(vld16), mv16);  chk("m_zero16", 32'(z16), 32'(m16 == 0));
    chk("m_cy16", 32'(cy16), mc16);    chk("m_bw16", 32'(bw16), mw16);
    chk("m_out8", 32'(out8), m8);      chk("m_bus8", 32'(bus8), mb8);
    chk("m_vld8", 32'(vld8), mv8);     chk("m_zero8", 32'(z8), 32'(m8 == 0));
    chk("m_cy8", 32'(cy8), mc8);       chk("m_bw8", 32'(bw8), mw8);
  end

  // Drive one cycle on the 16-bit instance (called at a negedge; returns at the next).
  task automatic c16(input bit ld, input logic [15:0] d, input bit wr, input bit up,
                     input bit dn, input logic [3:0] s);
    ld16 = ld; din16 = d; wr16 = wr; inc16 = up; dec16 = dn; st16 = s;
    ld8 = 0; wr8 = 0; inc8 = 0; dec8 = 0;
    @(negedge clk);
  endtask

  task automatic c8(input bit ld, input logic [7:0] d, input bit up, input bit dn,
                    input logic [3:0] s);
    ld8 = ld; din8 = d; wr8 = 0; inc8 = up; dec8 = dn; st8 = s;
    ld16 = 0; wr16 = 0; inc16 = 0; dec16 = 0;
    @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 0;
    #1 armed = 1;
    @(negedge clk);
    chk("rst_out16", 32'(out16), 32'h0100);
    chk("rst_out8", 32'(out8), 32'h00);
    chk("rst_zero8", 32'(z8), 32'h1);
    chk("rst_bus16", 32'(bus16), 32'h0);
    rst_n = 1;

    c16(0, 0, 0, 1, 0, 1);
    c16(0, 0, 0, 1, 0, 1);
    chk("count", 32'(out16), 32'h0102);
    #2 rst_n = 0;
    #1 chk("async_out16", 32'(out16), 32'h0100);
    @(negedge clk) rst_n = 1;

    c16(1, 16'hCAFE, 0, 0, 0, 0);
    chk("load", 32'(out16), 32'hCAFE);
    chk("load_zero", 32'(z16), 32'h0);

    c16(0, 0, 1, 1, 0, 1);
    chk("rpi_bus0", 32'(bus16), 32'hCAFE);
    chk("rpi_vld0", 32'(vld16), 32'h1);
    c16(0, 0, 1, 1, 0, 1);
    chk("rpi_bus1", 32'(bus16), 32'hCAFF);
    c16(0, 0, 1, 1, 0, 1);
    chk("rpi_bus2", 32'(bus16), 32'hCB00);
    chk("rpi_out", 32'(out16), 32'hCB01);
    c16(0, 0, 0, 0, 0, 0);
    chk("rpi_bus_off", 32'(bus16), 32'h0);
    chk("rpi_vld_off", 32'(vld16), 32'h0);

    c16(1, 16'hFFFE, 0, 0, 0, 0);
    c16(0, 0, 0, 1, 0, 3);
    chk("wrap_out", 32'(out16), 32'h0001);
    chk("wrap_cy", 32'(cy16), 32'h1);
    c16(0, 0, 0, 0, 1, 2);
    chk("wrapb_out", 32'(out16), 32'hFFFF);
    chk("wrapb_bw", 32'(bw16), 32'h1);
    chk("wrapb_cy", 32'(cy16), 32'h0);

    c16(0, 0, 0, 1, 1, 5);
    chk("both_out", 32'(out16), 32'hFFFF);
    chk("both_flags", {30'b0, cy16, bw16}, 32'h0);
    c16(1, 16'h1234, 0, 1, 0, 15);
    chk("ldinc_out", 32'(out16), 32'h1234);
    chk("ldinc_cy", 32'(cy16), 32'h0);
    c16(0, 0, 0, 1, 0, 0);
    chk("step0_out", 32'(out16), 32'h1234);
    chk("step0_cy", 32'(cy16), 32'h0);

    c8(1, 8'hFD, 0, 0, 0);
    c8(0, 0, 1, 0, 5);
    chk("sat_out", 32'(out8), 32'hFF);
    chk("sat_cy", 32'(cy8), 32'h1);
    c8(0, 0, 1, 0, 5);
    chk("sat_hold", 32'(out8), 32'hFF);
    chk("sat_cy2", 32'(cy8), 32'h1);
    c8(1, 8'h02, 0, 0, 0);
    chk("sat_ld_cy", 32'(cy8), 32'h0);
    c8(0, 0, 0, 1, 4);
    chk("satb_out", 32'(out8), 32'h00);
    chk("satb_bw", 32'(bw8), 32'h1);
    chk("satb_zero", 32'(z8), 32'h1);
    c8(0, 0, 0, 1, 1);
    chk("satb_hold_bw", 32'(bw8), 32'h1);
    c8(0, 0, 0, 0, 0);
    chk("satb_bw_off", 32'(bw8), 32'h0);

    c16(1, 16'hFFFF, 0, 0, 0, 0);
    c16(0, 0, 1, 1, 0, 1);
    chk("pre_rst_cy", 32'(cy16), 32'h1);
    chk("pre_rst_vld", 32'(vld16), 32'h1);
    chk("pre_rst_bus", 32'(bus16), 32'hFFFF);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_bus", 32'(bus16), 32'h0);
    chk("mid_rst_vld", 32'(vld16), 32'h0);
    chk("mid_rst_cy", 32'(cy16), 32'h0);
    chk("mid_rst_out", 32'(out16), 32'h0100);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
